mem_access_stage: RTL and testbench

- Load/store stage between the execute stage and the 1024x16 data RAM.
- Accepts one memory request at a time over a valid/ready handshake.
- Drives the RAM address, write data and write enable from registered values, so nothing glitches at the RAM's falling-edge write.
- Returns load data to writeback over a second valid/ready handshake; keeps load/store event counters.

---
 rtl/mem_access_stage_pkg.sv | 16 +
 rtl/mem_access_stage_event_counter.sv | 31 +++
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the load/store stage: default widths and FSM state encoding.
package mem_access_stage_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int TAG_W_DEF  = 3;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RESP  = 2'd3
    } mas_state_e;

endpackage

// File: rtl/mem_access_stage_event_counter.sv
// Free-running event counter: increments on en, wraps modulo 2^CNT_W.
module mas_event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage between execute and the 1024x16 data RAM. All RAM-side
// outputs come straight from flops so nothing glitches at the falling-edge write.
//
// state | meaning
// IDLE  | ready for a request; RAM outputs hold, mem_we low
// STORE | mem_we high for this single cycle
// LOAD  | address held one full cycle, read data captured at the end
// RESP  | load result presented until writeback takes it
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              addr_err,
    output logic [CNT_W-1:0]  load_count,
    output logic [CNT_W-1:0]  store_count
);

    mas_state_e        state_d,      state_q;
    logic [ADDR_W-1:0] mem_addr_d,   mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d,  mem_wdata_q;
    logic              mem_we_d,     mem_we_q;
    logic [TAG_W-1:0]  tag_d,        tag_q;
    logic              resp_valid_d, resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_d, resp_rdata_q;
    logic [TAG_W-1:0]  resp_tag_d,   resp_tag_q;
    logic              addr_err_d,   addr_err_q;
    logic              store_done;
    logic              load_done;

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        tag_d        = tag_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_tag_d   = resp_tag_q;
        addr_err_d   = 1'b0;
        store_done   = 1'b0;
        load_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    // Out-of-range addresses still go ahead on the truncated word address.
                    mem_addr_d  = req_addr[ADDR_W-1:0];
                    mem_wdata_d = req_wdata;
                    tag_d       = req_tag;
                    addr_err_d  = |req_addr[DATA_W-1:ADDR_W];
                    if (req_is_store) begin
                        mem_we_d = 1'b1;
                        state_d  = ST_STORE;
                    end else begin
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_STORE: begin
                store_done = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_LOAD: begin
                resp_rdata_d = mem_rdata;
                resp_tag_d   = tag_q;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    load_done    = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            tag_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_tag_q   <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_tag_q   <= resp_tag_d;
            addr_err_q   <= addr_err_d;
        end
    end

    mas_event_counter #(.CNT_W(CNT_W)) u_store_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (store_done),
        .count (store_count)
    );

    mas_event_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_done),
        .count (load_count)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_tag   = resp_tag_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a word-array memory model.
module tb_mem_access_stage;

    // Narrow counters so the wrap-around can be reached in a few hundred stores.
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_store;
    logic [15:0]   req_addr;
    logic [15:0]   req_wdata;
    logic [2:0]    req_tag;
    logic [9:0]    mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_we;
    logic [15:0]   mem_rdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [15:0]   resp_rdata;
    logic [2:0]    resp_tag;
    logic          addr_err;
    logic [CW-1:0] load_count;
    logic [CW-1:0] store_count;

    mem_access_stage #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_tag      (req_tag),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_tag     (resp_tag),
        .addr_err     (addr_err),
        .load_count   (load_count),
        .store_count  (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: asynchronous read, write on the falling edge.
    logic [15:0] ram [1024] = '{default: 16'h0000};
    always @(negedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    // Reference: what memory should contain, updated only when a store completes.
    logic [15:0]   ref_mem [1024] = '{default: 16'h0000};
    logic [CW-1:0] exp_store;
    logic [CW-1:0] exp_load;
    int            n_cmp;
    int            n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit st, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [2:0] tag, input int stall, input bit hold);
        int          w;
        logic [9:0]  a;
        logic [15:0] exp_d;
        a            = addr[9:0];
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = addr;
        req_wdata    = wd;
        req_tag      = tag;
        resp_ready   = (stall == 0);
        w = 0;
        while (!req_ready && w < 10) begin
            step();
            w++;
        end
        chk("req_ready_wait", req_ready, 1);
        chk("mem_we_idle", mem_we, 0);
        step();
        chk("addr_err_pulse", addr_err, (addr[15:10] != 6'd0));
        chk("mem_addr", mem_addr, a);
        chk("req_ready_busy", req_ready, 0);
        if (st) begin
            chk("mem_we_store", mem_we, 1);
            chk("mem_wdata", mem_wdata, wd);
            step();
            ref_mem[a] = wd;
            exp_store++;
            chk("mem_we_after", mem_we, 0);
            chk("store_count", store_count, exp_store);
            chk("req_ready_after_st", req_ready, 1);
            chk("addr_err_clear_st", addr_err, 0);
        end else begin
            chk("mem_we_load", mem_we, 0);
            exp_d = ref_mem[a];
            step();
            chk("resp_valid", resp_valid, 1);
            chk("resp_rdata", resp_rdata, exp_d);
            chk("resp_tag", resp_tag, tag);
            chk("req_ready_resp", req_ready, 0);
            chk("addr_err_clear_ld", addr_err, 0);
            chk("mem_we_resp", mem_we, 0);
            for (int i = 0; i < stall; i++) begin
                step();
                chk("stall_valid", resp_valid, 1);
                chk("stall_rdata", resp_rdata, exp_d);
                chk("stall_tag", resp_tag, tag);
                chk("stall_ready", req_ready, 0);
                chk("stall_load_count", load_count, exp_load);
            end
            resp_ready = 1'b1;
            step();
            exp_load++;
            chk("resp_valid_drop", resp_valid, 0);
            chk("load_count", load_count, exp_load);
            chk("req_ready_after_ld", req_ready, 1);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        step();
        step();
        rst_n     = 1'b1;
        exp_store = '0;
        exp_load  = '0;
        step();
    endtask

    initial begin
        logic [15:0] a16;
        logic [15:0] d16;
        n_cmp        = 0;
        n_fail       = 0;
        exp_store    = '0;
        exp_load     = '0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_tag      = '0;
        resp_ready   = 1'b0;
        step();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_tag", resp_tag, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_store_count", store_count, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_req_ready", req_ready, 1);
        rst_n = 1'b1;
        step();

        issue(1'b1, 16'h0005, 16'hBEEF, 3'd6, 0, 1'b0);
        step();
        chk("idle_holds_addr", mem_addr, 10'h005);
        issue(1'b0, 16'h0005, 16'h0000, 3'd3, 0, 1'b0);
        chk("beef_readback", ref_mem[5], 16'hBEEF);

        issue(1'b1, 16'h0405, 16'h1234, 3'd0, 0, 1'b0);
        issue(1'b0, 16'h0005, 16'h0000, 3'd1, 0, 1'b0);

        issue(1'b0, 16'h0005, 16'h0000, 3'd5, 5, 1'b0);

        issue(1'b1, 16'h0010, 16'hA5A5, 3'd2, 0, 1'b1);
        issue(1'b0, 16'h0010, 16'h0000, 3'd4, 0, 1'b1);
        issue(1'b1, 16'h0011, 16'h5A5A, 3'd1, 0, 1'b1);
        issue(1'b0, 16'h0011, 16'h0000, 3'd7, 0, 1'b0);

        // Reset while a load response is pending.
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 16'h0010; req_tag = 3'd2;
        resp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        chk("pre_rst_resp_valid", resp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_drop", resp_valid, 0);
        chk("rst_resp_rdata_clr", resp_rdata, 0);
        chk("rst_load_cnt_clr", load_count, 0);
        chk("rst_store_cnt_clr", store_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_store = '0;
        exp_load  = '0;
        step();
        chk("rst_resp_ready", req_ready, 1);

        // Reset during the write cycle: mem_we falls before the RAM's falling edge.
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 16'h0020; req_wdata = 16'hAAAA;
        step();
        req_valid = 1'b0;
        chk("pre_rst_mem_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_we_drop", mem_we, 0);
        chk("rst_store_cnt_st", store_count, 0);
        chk("rst_mem_addr_clr", mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("rst_store_ready", req_ready, 1);
        chk("rst_store_cnt_after", store_count, 0);
        issue(1'b0, 16'h0020, 16'h0000, 3'd0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a16 = 16'($urandom_range(0, 15)) + 16'h0020;
            if ($urandom_range(0, 3) == 0) a16[15:10] = 6'($urandom_range(1, 63));
            d16 = 16'($urandom);
            issue(1'($urandom_range(0, 1)), a16, d16, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        step();

        reset_dut();
        for (int i = 0; i < 255; i++) begin
            issue(1'b1, 16'h0100, 16'(i), 3'd0, 0, 1'b1);
        end
        chk("store_count_max", store_count, 8'hFF);
        issue(1'b1, 16'h0100, 16'hFFFF, 3'd0, 0, 1'b0);
        chk("store_count_wrap", store_count, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
